// File: rtl/seq_rot_left_unit.sv
// -----------------------------------------------------------------------------
// seq_rot_left_unit
//
// Multi-cycle rotate/shift unit for the execute stage. It moves the operand by
// up to two bit positions per clock, so a full-range shift costs
// ceil(cnt/2) RUN cycles. Left rotate/shift is the primary use. The right
// forms (ROR/SRL) are also supported, so one unit covers all four
// shift/rotate instructions.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; accepted only in IDLE or DONE
//   in     in   WIDTH  operand, captured on an accepted start
//   cnt    in   CNT_W  shift/rotate amount, captured on an accepted start
//   op     in   2      00 ROL, 01 SLL, 10 ROR, 11 SRL; captured on start
//   busy   out  1      high while the operation is stepping (RUN)
//   done   out  1      one-cycle pulse; out is valid in the same cycle
//   out    out  WIDTH  result register; holds until the next done
// -----------------------------------------------------------------------------
module seq_rot_left_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q,    op_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [CNT_W-1:0] rem_q,   rem_d;

  logic             step_two;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] rem_after;
  logic [WIDTH-1:0] stepped;

  // Moves d by one or two positions according to the captured operation.
  function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] d,
                                               input op_e              o,
                                               input logic             two);
    logic [WIDTH-1:0] r;
    r = d;
    case (o)
      OP_ROL: r = two ? {d[WIDTH-3:0], d[WIDTH-1:WIDTH-2]} : {d[WIDTH-2:0], d[WIDTH-1]};
      OP_SLL: r = two ? {d[WIDTH-3:0], 2'b00}              : {d[WIDTH-2:0], 1'b0};
      OP_ROR: r = two ? {d[1:0], d[WIDTH-1:2]}             : {d[0], d[WIDTH-1:1]};
      OP_SRL: r = two ? {2'b00, d[WIDTH-1:2]}              : {1'b0, d[WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Step size for this RUN cycle. An odd remainder finishes with a single step.
  assign step_two  = (rem_q >= CNT_W'(2));
  assign step      = step_two ? CNT_W'(2) : CNT_W'(1);
  assign rem_after = rem_q - step;
  assign stepped   = step_fn(data_q, op_q, step_two);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and infers a latch.
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    out_d   = out_q;

    case (state_q)
      // DONE accepts a new start exactly like IDLE, so operations can issue
      // back-to-back without an idle bubble.
      S_IDLE, S_DONE: begin
        if (start) begin
          data_d = in;
          rem_d  = cnt;
          op_d   = op_e'(op);
          if (cnt == '0) begin
            state_d = S_DONE;
            out_d   = in;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      // start is deliberately ignored here; the captured operands finish
      // undisturbed.
      S_RUN: begin
        data_d = stepped;
        rem_d  = rem_after;
        if (rem_after == '0) begin
          state_d = S_DONE;
          out_d   = stepped;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ROL;
      data_q  <= '0;
      rem_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign out  = out_q;

endmodule

// File: tb/tb_seq_rot_left_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_rot_left_unit
//
// Directed bench for seq_rot_left_unit. Each scenario task drives its own
// stimulus and compares the DUT outputs against hand-computed values.
// Outputs are sampled 1 time unit after the rising edge. Cycle numbering
// starts at the start cycle, which is cycle 0.
// -----------------------------------------------------------------------------
module tb_seq_rot_left_unit;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam int LIMIT = 40;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] in;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  int errors = 0;
  int checks = 0;

  seq_rot_left_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in   (in),
    .cnt  (cnt),
    .op   (op),
    .busy (busy),
    .done (done),
    .out  (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a start for one cycle. On return the bench sits in cycle 1.
  // The operand inputs are then scrambled, because the DUT must not look at
  // them again.
  task automatic start_op(input logic [1:0] o, input logic [WIDTH-1:0] d,
                          input logic [CNT_W-1:0] c);
    start = 1'b1;
    op    = o;
    in    = d;
    cnt   = c;
    tick();
    start = 1'b0;
    in    = WIDTH'($urandom);
    cnt   = CNT_W'($urandom);
    op    = 2'($urandom);
  endtask

  // Waits for done. lat is the cycle number (from the start cycle) in which
  // done was seen. nbusy counts the cycles with busy high before that.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 1;
    nbusy = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (busy === 1'b1) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    in    = '0;
    cnt   = '0;
    op    = 2'b00;
    tick();
    tick();
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: got out=%h busy=%b done=%b expected 0000/0/0",
                 i, out, busy, done);
      end
    end
  endtask

  task automatic test_odd_rol();
    int lat, nb;
    start_op(2'b00, 16'h8001, 4'd1);
    wait_done(lat, nb);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL odd_rol_timeout: done never seen within %0d cycles", LIMIT); end
    checks++; if (lat != 2) begin errors++; $display("FAIL odd_rol_latency: got %0d expected 2", lat); end
    checks++; if (nb != 1) begin errors++; $display("FAIL odd_rol_busy_cycles: got %0d expected 1", nb); end
    checks++; if (out !== 16'h0003) begin errors++; $display("FAIL odd_rol_out: got %h expected 0003", out); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL odd_rol_done_pulse: got %b expected 0", done); end
    checks++; if (out !== 16'h0003) begin errors++; $display("FAIL odd_rol_out_hold: got %h expected 0003", out); end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    start_op(2'b00, 16'h1234, 4'd4);
    wait_done(lat, nb);
    checks++; if (lat != 3) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 3", lat); end
    checks++; if (out !== 16'h2341) begin errors++; $display("FAIL b2b_first_out: got %h expected 2341", out); end
    // New start issued in the DONE cycle.
    start_op(2'b10, 16'h0001, 4'd2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
    checks++; if (out !== 16'h2341) begin errors++; $display("FAIL b2b_out_held_in_run: got %h expected 2341", out); end
    wait_done(lat, nb);
    checks++; if (lat != 2) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 2", lat); end
    checks++; if (out !== 16'h4000) begin errors++; $display("FAIL b2b_second_out: got %h expected 4000", out); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_return_idle: got done=%b busy=%b expected 0/0", done, busy); end
  endtask

  task automatic test_max_and_srl();
    int lat, nb;
    start_op(2'b01, 16'hFFFF, 4'd15);
    wait_done(lat, nb);
    checks++; if (lat != 9) begin errors++; $display("FAIL sll15_latency: got %0d expected 9", lat); end
    checks++; if (nb != 8) begin errors++; $display("FAIL sll15_busy_cycles: got %0d expected 8", nb); end
    checks++; if (out !== 16'h8000) begin errors++; $display("FAIL sll15_out: got %h expected 8000", out); end
    tick();
    start_op(2'b11, 16'h8000, 4'd3);
    wait_done(lat, nb);
    checks++; if (lat != 3) begin errors++; $display("FAIL srl3_latency: got %0d expected 3", lat); end
    checks++; if (out !== 16'h1000) begin errors++; $display("FAIL srl3_out: got %h expected 1000", out); end
    tick();
  endtask

  task automatic test_zero_and_ignored_start();
    int lat, nb;
    start_op(2'b10, 16'hBEEF, 4'd0);
    wait_done(lat, nb);
    checks++; if (lat != 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    checks++; if (nb != 0 || busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles, busy=%b expected 0", nb, busy); end
    checks++; if (out !== 16'hBEEF) begin errors++; $display("FAIL zero_out: got %h expected beef", out); end
    tick();
    // ROL 0x00F0 by 8, with a start during RUN that must be ignored.
    start_op(2'b00, 16'h00F0, 4'd8);
    start = 1'b1;
    in    = 16'h0000;
    cnt   = 4'd0;
    op    = 2'b01;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ignored_start_state: got busy=%b done=%b expected 1/0", busy, done); end
    wait_done(lat, nb);
    checks++; if (lat + 1 != 5) begin errors++; $display("FAIL ignored_start_latency: got %0d expected 5", lat + 1); end
    checks++; if (out !== 16'hF000) begin errors++; $display("FAIL ignored_start_out: got %h expected f000", out); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    start_op(2'b01, 16'h0F0F, 4'd9);
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy_before_reset: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrun_reset_flags: got busy=%b done=%b expected 0/0", busy, done); end
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL midrun_reset_out: got %h expected 0000", out); end
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || out !== 16'h0000) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL midrun_no_late_done: got activity after reset expected none"); end
  endtask

  initial begin
    test_reset();
    test_odd_rol();
    test_back_to_back();
    test_max_and_srl();
    test_zero_and_ignored_start();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_rot_left_unit.md
Name: seq_rot_left_unit

Overview:
- Multi-cycle rotate/shift unit that moves up to 2 bit positions per clock.
- Its primary direction is left (ROL/SLL), the counterpart to the existing right-by-2 barrel stage; it also supports ROR/SRL so one unit covers all four cases.
- Sits beside the ALU as an area-reduced shifter with a start/busy/done handshake, used by the execute stage for shift/rotate instructions.

Parameters:
- WIDTH, 16, data width in bits.
- CNT_W, 4, shift-amount width; maximum shift is 2^CNT_W-1 = 15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when state is IDLE or DONE.
- in  input  WIDTH  operand; captured on an accepted start.
- cnt  input  CNT_W  shift/rotate amount; captured on an accepted start.
- op  input  2  operation, captured on an accepted start: 00 ROL, 01 SLL (zero fill), 10 ROR, 11 SRL (zero fill).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; `out` is valid in the same cycle.
- out  output  WIDTH  result register; holds the last result until the next done.

Behaviour:
- Reset: when rst=1 at a clock edge, state=IDLE, out=0x0000, busy=0, done=0, and internal data/remaining/op registers clear. This applies in any state, including mid-RUN; a partial result is discarded and done is not pulsed.
- State machine has three states: IDLE, RUN, DONE.
- busy=1 only in RUN. done=1 only in DONE.
- IDLE:
  - start=1 loads data=in, rem=cnt, op_r=op.
  - If cnt==0, go to DONE; otherwise go to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - step = 2 if rem>=2, else 1.
  - data = op_r(data, step); rem = rem - step.
  - If rem-step==0, go to DONE and load out with the stepped data in the same edge; otherwise stay in RUN.
- cnt==0 path: the IDLE→DONE transition loads out=in unchanged.
- DONE: done=1 for exactly one cycle.
  - start=1 is accepted exactly as in IDLE; back-to-back operations are legal.
  - start=0: go to IDLE.
- Latency: for an accepted start at edge T, done is high in the cycle following edge T+ceil(cnt/2). Cycle counts from the start cycle: cnt 0 → 1, cnt 1 or 2 → 2, cnt 15 → 9.
- start while in RUN is ignored: operands are not re-captured and the current operation completes unaffected.
- Step functions:
  - ROL by k: data = {data[W-1-k:0], data[W-1:W-k]}.
  - SLL by k: data = {data[W-1-k:0], k'b0}.
  - ROR by k: data = {data[k-1:0], data[W-1:k]}.
  - SRL by k: data = {k'b0, data[W-1:k]}.
- Wrap-around: ROL/ROR are modulo WIDTH. SLL/SRL by 15 leave a single surviving bit.
- `out` changes only on the edge entering DONE (or on reset). It holds stable through the following IDLE and RUN cycles.
- in, cnt and op may change freely after the accepted start; they are don't-care outside start-accept cycles.

Test Plan:
- Reset and idle:
  - Stimulus: rst=1 for 2 cycles, then release with start=0.
  - Required response: out=0x0000, busy=0, done=0, all held for 5 cycles.
- Odd count (ROL):
  - Stimulus: op=00, in=0x8001, cnt=1, start at T.
  - Required response: busy=1 for 1 cycle; done=1 with out=0x0003 at T+2 (cycle count).
- Even count, back-to-back:
  - Stimulus: op=00, in=0x1234, cnt=4 → out=0x2341 with done at cycle 3.
  - Then, in the DONE cycle, start again with op=10, in=0x0001, cnt=2.
  - Required response: second result out=0x4000, done 2 cycles later.
- Maximum count and SRL:
  - Stimulus: op=01, in=0xFFFF, cnt=15.
  - Required response: out=0x8000, done at cycle 9, busy high for 8 cycles.
  - Stimulus: op=11, in=0x8000, cnt=3.
  - Required response: out=0x1000.
- Zero count and ignored start:
  - Stimulus: cnt=0, in=0xBEEF, any op.
  - Required response: done next cycle with out=0xBEEF, busy never high.
  - Stimulus: start with in=0x0000 during RUN of ROL 0x00F0 by 8.
  - Required response: the RUN start is ignored; out=0xF000.
- Reset mid-operation:
  - Stimulus: assert rst during RUN of SLL 0x0F0F by 9.
  - Required response: next cycle state=IDLE, busy=0, done=0, out=0x0000, and no done pulse follows.
